// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory req/ack sequencer and IF/ID register
// for the 5-stage MIPS core. A one-entry skid buffer keeps a word that
// returns while decode is stalled. Redirects that arrive while a request is
// outstanding are remembered and applied once the abandoned word comes back.
// Optional: define FETCH_PERF_EN to add saturating stall/redirect counters.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic [5:0]        op,
    output logic [5:0]        func,
    output logic              fetch_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_redirect_cnt
`endif
);

    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc4;
    logic              pend_redir;
    logic [ADDR_W-1:0] pend_pc;
    logic              req_q;
    logic              drop;

    assign pc4        = pc + FOUR;
    // the word being acked belongs to a path that has already been abandoned
    assign drop       = redirect | pend_redir;

    assign imem_req   = req_q;
    assign imem_addr  = pc;
    assign op         = if_id_instr[31:26];
    assign func       = if_id_instr[5:0];
    assign fetch_busy = (state != IDLE);

    // Fetch FSM: PC, skid buffer, pending redirect and the IF/ID register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            pc          <= RESET_PC;
            skid_instr  <= '0;
            skid_pc4    <= '0;
            pend_redir  <= 1'b0;
            pend_pc     <= '0;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        if (drop) begin
                            // returning word is stale: discard and jump
                            pc          <= redirect ? redirect_pc : pend_pc;
                            pend_redir  <= 1'b0;
                            if_id_instr <= '0;
                            if_id_pc4   <= '0;
                            if_id_valid <= 1'b0;
                        end else if (stall) begin
                            // decode can't take it yet: park it in the skid
                            skid_instr <= imem_rdata;
                            skid_pc4   <= pc4;
                            pc         <= pc4;
                            state      <= HOLD;
                            req_q      <= 1'b0;
                        end else begin
                            if_id_instr <= imem_rdata;
                            if_id_pc4   <= pc4;
                            if_id_valid <= 1'b1;
                            pc          <= pc4;
                        end
                    end else if (redirect) begin
                        // address must stay put until the ack; remember target
                        pend_redir  <= 1'b1;
                        pend_pc     <= redirect_pc;
                        if_id_instr <= '0;
                        if_id_pc4   <= '0;
                        if_id_valid <= 1'b0;
                    end else if (!stall) begin
                        if_id_instr <= '0;
                        if_id_pc4   <= '0;
                        if_id_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc          <= redirect_pc;
                        if_id_instr <= '0;
                        if_id_pc4   <= '0;
                        if_id_valid <= 1'b0;
                        state       <= REQ;
                        req_q       <= 1'b1;
                    end else if (!stall) begin
                        if_id_instr <= skid_instr;
                        if_id_pc4   <= skid_pc4;
                        if_id_valid <= 1'b1;
                        state       <= REQ;
                        req_q       <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counts of stall cycles and redirect cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (stall && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
            if (redirect && (perf_redirect_cnt != 16'hFFFF)) begin
                perf_redirect_cnt <= perf_redirect_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A memory model with
// programmable latency answers requests with rdata = address; each scenario
// pushes the IF/ID words it expects and a monitor pops them as they appear.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        fetch_busy;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_redirect_cnt;
    logic [15:0] d2_perf_stall_cnt;
    logic [15:0] d2_perf_redirect_cnt;
`endif

    // second instance with a PC that wraps on its second fetch
    logic        d2_stall = 1'b0;
    logic        d2_redirect = 1'b0;
    logic [31:0] d2_redirect_pc = '0;
    logic        d2_req;
    logic [31:0] d2_addr;
    logic        d2_ack;
    logic [31:0] d2_rdata;
    logic [31:0] d2_instr;
    logic [31:0] d2_pc4;
    logic        d2_valid;
    logic [5:0]  d2_op;
    logic [5:0]  d2_func;
    logic        d2_busy;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mem_lat = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .op(op), .func(func),
        .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    assign d2_ack   = d2_req;
    assign d2_rdata = d2_addr;

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .stall(d2_stall), .redirect(d2_redirect),
        .redirect_pc(d2_redirect_pc), .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_ack(d2_ack), .imem_rdata(d2_rdata), .if_id_instr(d2_instr),
        .if_id_pc4(d2_pc4), .if_id_valid(d2_valid), .op(d2_op), .func(d2_func),
        .fetch_busy(d2_busy)
`ifdef FETCH_PERF_EN
        , .perf_stall_cnt(d2_perf_stall_cnt), .perf_redirect_cnt(d2_perf_redirect_cnt)
`endif
    );

    // memory: acks after mem_lat waiting cycles, decided at the falling edge
    initial begin : mem_model
        int          cnt;
        bit          pend;
        logic [31:0] paddr;
        cnt = 0; pend = 1'b0; paddr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                imem_ack = 1'b0; cnt = 0; pend = 1'b0;
            end else if (imem_req) begin
                if (pend) begin
                    checks++;
                    if (imem_addr !== paddr) begin
                        errors++;
                        $display("FAIL addr_stable: imem_addr=%h required %h", imem_addr, paddr);
                    end
                end
                if (cnt >= mem_lat) begin
                    imem_ack = 1'b1; imem_rdata = imem_addr; cnt = 0;
                end else begin
                    imem_ack = 1'b0; cnt++;
                end
                pend  = !imem_ack;
                paddr = imem_addr;
            end else begin
                imem_ack = 1'b0; cnt = 0; pend = 1'b0;
            end
        end
    end

    // scoreboard: each newly loaded IF/ID word must match the queue head
    initial begin : sb_monitor
        bit          pv;
        logic [31:0] ppc4;
        exp_t        e;
        pv = 1'b0; ppc4 = '0;
        forever begin
            @(negedge clk);
            if (mon_en && if_id_valid && !(pv && if_id_pc4 == ppc4)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got instr=%h pc4=%h, no word expected", if_id_instr, if_id_pc4);
                end else begin
                    e = exp_q.pop_front();
                    if (if_id_instr !== e.instr || if_id_pc4 !== e.pc4) begin
                        errors++;
                        $display("FAIL sb_word: got instr=%h pc4=%h expected instr=%h pc4=%h",
                                 if_id_instr, if_id_pc4, e.instr, e.pc4);
                    end
                end
            end else if (mon_en && !if_id_valid) begin
                checks++;
                if (if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
                    errors++;
                    $display("FAIL bubble: got instr=%h pc4=%h expected 0/0", if_id_instr, if_id_pc4);
                end
            end
            pv   = if_id_valid;
            ppc4 = if_id_pc4;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        e.instr = i;
        e.pc4   = p;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int lat);
        mon_en = 1'b0; rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mem_lat = lat;
        cyc();
        cyc();
        exp_q.delete();
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        mon_en = 1'b0; rst = 1'b1;
        cyc();
        checks++;
        if ({imem_req, imem_addr, fetch_busy} !== '0) begin
            errors++;
            $display("FAIL reset_req: got req=%b addr=%h busy=%b expected 0", imem_req, imem_addr, fetch_busy);
        end
        checks++;
        if ({if_id_valid, if_id_instr, if_id_pc4, op, func} !== '0) begin
            errors++;
            $display("FAIL reset_ifid: got v=%b instr=%h pc4=%h op=%h func=%h expected 0",
                     if_id_valid, if_id_instr, if_id_pc4, op, func);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (imem_req !== 1'b1 || fetch_busy !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req: got req=%b busy=%b addr=%h expected 1/1/0", imem_req, fetch_busy, imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(0);
        for (int i = 0; i < 6; i++) push(32'(4 * i), 32'(4 * i + 4));
        for (int k = 1; k <= 7; k++) begin
            cyc();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1))) begin
                errors++;
                $display("FAIL b2b_addr: cycle %0d got req=%b addr=%h expected 1/%h", k, imem_req, imem_addr, 4 * (k - 1));
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d words never appeared, expected 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        do_reset(0);
        push(32'h0, 32'h4); push(32'h4, 32'h8); push(32'h8, 32'hC);
        push(32'hC, 32'h10); push(32'h10, 32'h14);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k >= 3 && k <= 5) stall = 1'b1;
            else stall = 1'b0;
            if (k == 4 || k == 5) begin
                checks++;
                if (imem_req !== 1'b0 || fetch_busy !== 1'b1 || if_id_valid !== 1'b1 || if_id_instr !== 32'h4) begin
                    errors++;
                    $display("FAIL stall_hold: cycle %0d got req=%b busy=%b v=%b instr=%h expected 0/1/1/4",
                             k, imem_req, fetch_busy, if_id_valid, if_id_instr);
                end
            end
            if (k == 7) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
                    errors++;
                    $display("FAIL stall_resume: got req=%b addr=%h expected 1/c", imem_req, imem_addr);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: %0d words never appeared, expected 0", exp_q.size());
        end
    endtask

    task automatic test_redirect();
        do_reset(0);
        push(32'h0, 32'h4); push(32'h40, 32'h44); push(32'h44, 32'h48);
        push(32'hFC00_0024, 32'hFC00_0028);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            redirect = (k == 2) || (k == 5);
            redirect_pc = (k == 2) ? 32'h40 : 32'hFC00_0024;
            if (k == 3) begin
                checks++;
                if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
                    errors++;
                    $display("FAIL redir_target: got v=%b req=%b addr=%h expected 0/1/40", if_id_valid, imem_req, imem_addr);
                end
            end
            if (k == 6) begin
                checks++;
                if (if_id_valid !== 1'b0 || imem_addr !== 32'hFC00_0024) begin
                    errors++;
                    $display("FAIL redir2_target: got v=%b addr=%h expected 0/fc000024", if_id_valid, imem_addr);
                end
            end
            if (k == 7) begin
                checks++;
                if (op !== 6'h3F || func !== 6'h24) begin
                    errors++;
                    $display("FAIL op_func: got op=%h func=%h expected 3f/24", op, func);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL redir_drain: %0d words never appeared, expected 0", exp_q.size());
        end
    endtask

    task automatic test_latency_redirect();
        do_reset(3);
        push(32'h0, 32'h4); push(32'h4, 32'h8); push(32'h8, 32'hC);
        push(32'hC, 32'h10); push(32'h80, 32'h84);
        for (int k = 1; k <= 25; k++) begin
            cyc();
            redirect = (k == 18);
            redirect_pc = 32'h80;
            if (k == 19 || k == 20) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL lat_pending: cycle %0d got req=%b addr=%h v=%b expected 1/10/0",
                             k, imem_req, imem_addr, if_id_valid);
                end
            end
            if (k == 21) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h80 || if_id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL lat_target: got req=%b addr=%h v=%b expected 1/80/0", imem_req, imem_addr, if_id_valid);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lat_drain: %0d words never appeared, expected 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_in_hold();
        do_reset(0);
        push(32'h0, 32'h4); push(32'h4, 32'h8); push(32'h200, 32'h204); push(32'h204, 32'h208);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            stall = (k == 3) || (k == 4);
            redirect = (k == 4);
            redirect_pc = 32'h200;
            if (k == 5) begin
                checks++;
                if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
                    errors++;
                    $display("FAIL hold_redir: got v=%b req=%b addr=%h expected 0/1/200", if_id_valid, imem_req, imem_addr);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_drain: %0d words never appeared, expected 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset(0);
        mon_en = 1'b0;
        cyc();
        checks++;
        if (d2_req !== 1'b1 || d2_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first: got req=%b addr=%h expected 1/fffffffc", d2_req, d2_addr);
        end
        cyc();
        checks++;
        if (d2_addr !== 32'h0 || d2_valid !== 1'b1 || d2_instr !== 32'hFFFF_FFFC || d2_pc4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_second: got addr=%h v=%b instr=%h pc4=%h expected 0/1/fffffffc/0",
                     d2_addr, d2_valid, d2_instr, d2_pc4);
        end
    endtask

    task automatic test_rst_mid();
        do_reset(0);
        mon_en = 1'b0;
        cyc(); cyc(); cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || fetch_busy !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: got req=%b busy=%b v=%b instr=%h addr=%h expected all 0",
                     imem_req, fetch_busy, if_id_valid, if_id_instr, imem_addr);
        end
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_restart: got req=%b addr=%h expected 1/0", imem_req, imem_addr);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset(0);
        mon_en = 1'b0;
        checks++;
        if (perf_stall_cnt !== 16'd0 || perf_redirect_cnt !== 16'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_stall_cnt, perf_redirect_cnt);
        end
        for (int k = 1; k <= 11; k++) begin
            cyc();
            stall = (k <= 5);
            redirect = (k == 7) || (k == 9);
            redirect_pc = 32'h100;
        end
        checks++;
        if (perf_stall_cnt !== 16'd5 || perf_redirect_cnt !== 16'd2) begin
            errors++;
            $display("FAIL perf_count: got %0d/%0d expected 5/2", perf_stall_cnt, perf_redirect_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (perf_stall_cnt !== 16'd0 || perf_redirect_cnt !== 16'd0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            errors++;
            $display("FAIL perf_clear: got %0d/%0d v=%b instr=%h expected 0/0/0/0",
                     perf_stall_cnt, perf_redirect_cnt, if_id_valid, if_id_instr);
        end
        cyc();
    endtask
`endif

    initial begin : main
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_latency_redirect();
        test_redirect_in_hold();
        test_wrap();
        test_rst_mid();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
